// File: rtl/uart_rx_ctrl_if.sv
// Purpose: byte + error flags handed from the UART receive sequencer to its consumer.
// Latency: none, this is a bundle of wires.
// Backpressure: valid/ready. The producer may overwrite an unaccepted byte and flags that on its own port.
interface uart_rx_ctrl_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       parity_err;
  logic       frame_err;

  modport master (output data, output valid, output parity_err, output frame_err, input ready);
  modport slave  (input data, input valid, input parity_err, input frame_err, output ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// Purpose: UART receive sequencer. It synchronises RX, times the bits, checks the start bit and assembles the byte.
// Latency: the byte is valid 1 cycle after the mid-stop sample (T0+153, or T0+169 with parity, at 16x).
// Backpressure: none toward the line. A commit onto an unaccepted byte overwrites it and pulses o_overrun.
module uart_rx_ctrl #(
  parameter int OverSample = 16,
  parameter int Parity     = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx,
  output logic                  o_half,
  output logic                  o_strobe,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_false_start,
  uart_rx_ctrl_if.master        rx_out
);

  localparam int CntW = $clog2(OverSample);
  localparam logic [CntW-1:0] HalfCnt = CntW'(OverSample / 2 - 1);
  localparam logic [CntW-1:0] EndCnt  = CntW'(OverSample - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            rx_m, rx_s;
  logic [CntW-1:0] os_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            armed;
  logic            perr;
  logic            at_half, at_end, commit;
  logic [7:0]      data_q;
  logic            valid_q, parity_err_q, frame_err_q;

  assign at_half = (os_cnt == HalfCnt);
  assign at_end  = (os_cnt == EndCnt);

  // Two-flop synchroniser on the raw line, reset to the idle (high) level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode, start-bit rejection and commit strobe
  always_comb begin
    state_nxt     = state;
    o_false_start = 1'b0;
    commit        = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && !rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (at_half && rx_s) begin
          state_nxt     = S_IDLE;
          o_false_start = 1'b1;
        end else if (at_end) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (at_end && bit_cnt == 3'd7) state_nxt = (Parity != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (at_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leave at mid-stop so a start bit in the second half of the stop bit is caught
        if (at_half) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit timing, shift register, parity and the re-arm guard used after a break
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      os_cnt  <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      perr    <= 1'b0;
      armed   <= 1'b1;
    end else begin
      if (state == S_IDLE || state_nxt == S_IDLE) os_cnt <= '0;
      else if (at_end)                            os_cnt <= '0;
      else                                        os_cnt <= os_cnt + 1'b1;

      if (state == S_START && at_end)                          bit_cnt <= 3'd0;
      else if (state == S_DATA && at_end && bit_cnt != 3'd7)   bit_cnt <= bit_cnt + 3'd1;

      if (state == S_DATA && at_half) shift <= {rx_s, shift[7:1]};

      if (state == S_PARITY && at_half) perr <= rx_s ^ (^shift);

      if (commit && !rx_s)                armed <= 1'b0;
      else if (state == S_IDLE && rx_s)   armed <= 1'b1;
    end
  end

  // Output holding register: commit loads it, accept drops valid unless a commit lands the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (commit) begin
      data_q       <= shift;
      parity_err_q <= perr;
      frame_err_q  <= ~rx_s;
      valid_q      <= 1'b1;
    end else if (valid_q && rx_out.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign rx_out.data       = data_q;
  assign rx_out.valid      = valid_q;
  assign rx_out.parity_err = parity_err_q;
  assign rx_out.frame_err  = frame_err_q;

  assign o_overrun = commit & valid_q & ~rx_out.ready;
  assign o_busy    = (state != S_IDLE);
  assign o_half    = at_half & (state == S_DATA || state == S_PARITY || state == S_STOP);
  assign o_strobe  = at_end & (state == S_START || state == S_DATA || state == S_PARITY);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose: bench for uart_rx_ctrl with one instance without parity and one with even parity.
// Latency: checks the byte arrival cycle and the half/strobe/overrun/false-start pulse cycles against T0.
// Backpressure: drives ready low to force overwrites, and pulses ready in the commit cycle.
module tb_uart_rx_ctrl;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx0, rx1, rdy0, rdy1;
  logic half0, str0, busy0, ov0, fs0;
  logic half1, str1, busy1, ov1, fs1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t e0, e1;
  int   half_q[$];
  int   str_q[$];
  int   ov_q[$];
  int   fs_q[$];
  int   vrise0 = -1;
  int   vrise1 = -1;
  logic pv0 = 1'b0;
  logic pv1 = 1'b0;

  uart_rx_ctrl_if bus0();
  uart_rx_ctrl_if bus1();
  assign bus0.ready = rdy0;
  assign bus1.ready = rdy1;

  uart_rx_ctrl #(.OverSample(16), .Parity(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx0),
    .o_half(half0), .o_strobe(str0), .o_busy(busy0),
    .o_overrun(ov0), .o_false_start(fs0), .rx_out(bus0)
  );

  uart_rx_ctrl #(.OverSample(16), .Parity(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx1),
    .o_half(half1), .o_strobe(str1), .o_busy(busy1),
    .o_overrun(ov1), .o_false_start(fs1), .rx_out(bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx1 = v;
    else     rx0 = v;
  endtask

  // One frame of 16-cycle bits starting in the current cycle; c is the cycle the start bit was driven
  task automatic send_frame(input bit sel, input logic [7:0] b, input bit par_en,
                            input logic par, input logic stop, output int c);
    c = cyc;
    set_rx(sel, 1'b0);
    repeat (16) tick();
    for (int k = 0; k < 8; k++) begin
      set_rx(sel, b[k]);
      repeat (16) tick();
    end
    if (par_en) begin
      set_rx(sel, par);
      repeat (16) tick();
    end
    set_rx(sel, stop);
    repeat (16) tick();
    set_rx(sel, 1'b1);
  endtask

  function automatic int q_first(input int q[$]);
    return (q.size() == 0) ? -1 : q[0];
  endfunction

  function automatic int q_last(input int q[$]);
    return (q.size() == 0) ? -1 : q[q.size()-1];
  endfunction

  function automatic int count_before(input int q[$], input int lim);
    int n = 0;
    foreach (q[i]) if (q[i] < lim) n++;
    return n;
  endfunction

  // Monitor: pulse logging and scoreboard pops on every accepted byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (half0) half_q.push_back(cyc);
      if (str0)  str_q.push_back(cyc);
      if (ov0)   ov_q.push_back(cyc);
      if (fs0)   fs_q.push_back(cyc);
      if (bus0.valid && !pv0) vrise0 <= cyc;
      if (bus1.valid && !pv1) vrise1 <= cyc;
      pv0 <= bus0.valid;
      pv1 <= bus1.valid;
      if (bus0.valid && rdy0) begin
        if (exp_q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte0: got 0x%0h, expected no byte", bus0.data);
        end else begin
          e0 = exp_q0.pop_front();
          check("data0", {24'd0, bus0.data}, {24'd0, e0.data});
          check("perr0", {31'd0, bus0.parity_err}, {31'd0, e0.perr});
          check("ferr0", {31'd0, bus0.frame_err}, {31'd0, e0.ferr});
        end
      end
      if (bus1.valid && rdy1) begin
        if (exp_q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte1: got 0x%0h, expected no byte", bus1.data);
        end else begin
          e1 = exp_q1.pop_front();
          check("data1", {24'd0, bus1.data}, {24'd0, e1.data});
          check("perr1", {31'd0, bus1.parity_err}, {31'd0, e1.perr});
          check("ferr1", {31'd0, bus1.frame_err}, {31'd0, e1.ferr});
        end
      end
    end else begin
      pv0 <= 1'b0;
      pv1 <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c, cx, t0, prev_vr;
    rst_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) tick();
    check("rst_valid",  {31'd0, bus0.valid}, 32'd0);
    check("rst_busy",   {31'd0, busy0}, 32'd0);
    check("rst_data",   {24'd0, bus0.data}, 32'd0);
    check("rst_flags",  {30'd0, bus0.parity_err, bus0.frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();

    // Basic byte 0xA5, no parity
    half_q.delete(); str_q.delete();
    exp_q0.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, c);
    t0 = c + 2;
    repeat (4) tick();
    check("basic_valid_cycle", vrise0, t0 + 153);
    check("basic_data_halves", count_before(half_q, t0 + 145), 32'd8);
    check("basic_first_half",  q_first(half_q), t0 + 24);
    check("basic_stop_half",   q_last(half_q), t0 + 152);
    check("basic_strobes",     str_q.size(), 32'd9);
    check("basic_first_strobe", q_first(str_q), t0 + 16);
    check("basic_last_strobe", q_last(str_q), t0 + 144);

    // Glitch of 4 cycles
    fs_q.delete();
    prev_vr = vrise0;
    c = cyc;
    rx0 = 1'b0;
    repeat (4) tick();
    rx0 = 1'b1;
    repeat (40) tick();
    check("glitch_fs_count", fs_q.size(), 32'd1);
    check("glitch_fs_cycle", q_first(fs_q), c + 2 + 8);
    check("glitch_busy",     {31'd0, busy0}, 32'd0);
    check("glitch_no_valid", vrise0, prev_vr);

    // Even parity: 0x03 has even weight, so parity bit 1 is an error and 0 is clean
    exp_q1.push_back('{data: 8'h03, perr: 1'b1, ferr: 1'b0});
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, c);
    repeat (4) tick();
    check("parity_valid_cycle", vrise1, c + 2 + 169);
    exp_q1.push_back('{data: 8'h03, perr: 1'b0, ferr: 1'b0});
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, c);
    repeat (4) tick();

    // Overrun: back-to-back frames with ready low
    rdy0 = 1'b0;
    ov_q.delete();
    exp_q0.push_back('{data: 8'h22, perr: 1'b0, ferr: 1'b0});
    c = cyc;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, cx);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, cx);
    repeat (4) tick();
    check("overrun_count", ov_q.size(), 32'd1);
    check("overrun_cycle", q_first(ov_q), c + 314);
    check("overrun_data",  {24'd0, bus0.data}, 32'h22);
    rdy0 = 1'b1;
    repeat (3) tick();
    check("overrun_drained", exp_q0.size(), 32'd0);

    // Same pair, ready pulsed in the second commit cycle: no overrun
    rdy0 = 1'b0;
    exp_q0.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
    exp_q0.push_back('{data: 8'h22, perr: 1'b0, ferr: 1'b0});
    c = cyc;
    fork
      begin
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, cx);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, cx);
      end
      begin
        wait_until(c + 314);
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
      end
    join
    repeat (4) tick();
    check("no_overrun_count", ov_q.size(), 32'd1);
    check("no_overrun_valid", {31'd0, bus0.valid}, 32'd1);
    rdy0 = 1'b1;
    repeat (3) tick();
    check("no_overrun_drained", exp_q0.size(), 32'd0);

    // Break: line low for 30 bit times
    exp_q0.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
    c = cyc;
    rx0 = 1'b0;
    wait_until(c + 300);
    check("break_idle", {31'd0, busy0}, 32'd0);
    wait_until(c + 480);
    rx0 = 1'b1;
    check("break_valid_cycle", vrise0, c + 155);
    repeat (32) tick();
    check("break_single_frame", exp_q0.size(), 32'd0);
    exp_q0.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, cx);
    repeat (4) tick();
    check("after_break_frame", exp_q0.size(), 32'd0);

    // Reset during data bit 3 with a byte still pending
    rdy0 = 1'b0;
    send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, cx);
    repeat (2) tick();
    check("pending_before_rst", {31'd0, bus0.valid}, 32'd1);
    c = cyc;
    fork
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, cx);
      begin
        wait_until(c + 72);
        check("busy_before_rst", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  {31'd0, busy0}, 32'd0);
        check("midrst_valid", {31'd0, bus0.valid}, 32'd0);
        check("midrst_data",  {24'd0, bus0.data}, 32'd0);
        check("midrst_pulses", {28'd0, half0, str0, ov0, fs0}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
      end
    join
    repeat (20) tick();
    rdy0 = 1'b1;
    exp_q0.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, cx);
    repeat (4) tick();
    check("after_rst_frame", exp_q0.size(), 32'd0);
    check("parity_drained",  exp_q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
